// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one sum bit per clock, LSB first.
// Latches in1/in2/c_in on start, runs WIDTH cycles through a single carry
// flip-flop, then presents {c_out, sum} with a one-cycle done pulse.
// Optional build macro: SERIAL_ADDER_SUB_EN adds a sub port selecting
// two's-complement subtraction (B and carry-in loaded inverted).
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; operands sampled on the accepting edge
// ST_RUN  | one bit processed per edge, LSB first
// ST_DONE | result registered, done high for this single cycle
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // Counter must hold at least 1 bit even when WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_nxt;
  logic             carry;
  logic             carry_nxt;
  logic             s_bit;
  logic             sub_sel;
  logic             last_bit;
  logic [CW-1:0]    bit_cnt;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  // Full-adder slice on the current LSBs; new bit enters the partial-sum MSB.
  always_comb begin
    s_bit               = a_sr[0] ^ b_sr[0] ^ carry;
    carry_nxt           = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    psum_nxt            = psum >> 1;
    psum_nxt[WIDTH-1]   = s_bit;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state; busy falls exactly as done rises.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Operand shift registers, carry, partial sum and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      psum    <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr    <= in1;
            b_sr    <= in2 ^ {WIDTH{sub_sel}};
            carry   <= c_in ^ sub_sel;
            psum    <= '0;
            bit_cnt <= '0;
          end
        end
        ST_RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry   <= carry_nxt;
          psum    <= psum_nxt;
          bit_cnt <= bit_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers update only on the final RUN edge, so partial sums never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else if (state == ST_RUN && last_bit) begin
      sum   <= psum_nxt;
      c_out <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed test of serial_adder (WIDTH=8 main instance plus
// a WIDTH=1 instance for the full-adder table). A timestamp-based model
// predicts busy/done/result every cycle; literal expectations pin the model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         c_in = 1'b0;
  logic         sub_v = 1'b0;
  logic         busy, done, c_out;
  logic [W-1:0] sum;

  logic st1 = 1'b0, a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
  logic busy1, done1, sum1, co1;

  int  n_checks = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v),
`endif
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .in1(a1), .in2(b1), .c_in(ci1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .c_out(co1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic result {c_out, sum} of one operation.
  function automatic logic [W:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~c};
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Model: an op accepted at edge k is busy after edges k..k+W-1, done after
  // edge k+W, idle again after k+W+1; a new start is accepted from k+W+2.
  int         edge_n = 0;
  int         last_acc = -100;
  logic [W:0] pend = '0;
  logic [W:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_acc = edge_n - 100;
      m_res    = '0;
    end else begin
      edge_n++;
      if (edge_n - last_acc == W) m_res = pend;
      if (start && (edge_n - last_acc >= W + 2)) begin
        last_acc = edge_n;
        pend     = model_res(in1, in2, c_in, sub_v);
      end
    end
  end

  // Every-cycle comparison of the WIDTH=8 instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", busy, ((edge_n - last_acc) < W) ? 1'b1 : 1'b0);
      chk("m_done", done, ((edge_n - last_acc) == W) ? 1'b1 : 1'b0);
      chk("m_result", {c_out, sum}, m_res);
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s);
    @(negedge clk);
    in1 = a; in2 = b; c_in = c; sub_v = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns number of cycles from the start edge to done, and busy cycles seen.
  task automatic wait_done(input string name, output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, done, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic [W:0] exp);
    int n, nb;
    start_op(a, b, c, s);
    wait_done(name, n, nb);
    chk({name, "_lat"}, n, W);
    chk({name, "_busy"}, nb, W);
    chk({name, "_res"}, {c_out, sum}, exp);
  endtask

  logic [1:0] fa_tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    int n, nb;
    int d0, d1, nd;

    // Reset held with start high: everything stays 0.
    #1 rst_n = 1'b0;
    in1 = 8'h3C; in2 = 8'h5A; c_in = 1'b0; start = 1'b1;
    #1 chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_res", {c_out, sum}, 9'h000);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_first_accept", busy, 1'b1);
    start = 1'b0;
    wait_done("basic", n, nb);
    chk("basic_lat", n, 8);
    chk("basic_busy", nb, 8);
    chk("basic_res", {c_out, sum}, 9'h096);

    // Carry chain.
    run_op("carry1", 8'hFF, 8'h01, 1'b1, 1'b0, 9'h101);
    run_op("carry2", 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);
    run_op("mixed", 8'hA7, 8'h3B, 1'b1, 1'b0, 9'h0E3);

    // Busy protection: second request at RUN cycle 3 is ignored.
    start_op(8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    in1 = 8'hAA; in2 = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busyprot", n, nb);
    chk("busyprot_res", {c_out, sum}, 9'h003);
    repeat (12) @(negedge clk);
    chk("busyprot_idle", busy, 1'b0);
    chk("busyprot_hold", {c_out, sum}, 9'h003);

    // Abort mid-RUN.
    start_op(8'h77, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_res", {c_out, sum}, 9'h000);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_nodone_res", {c_out, sum}, 9'h000);
    run_op("after_abort", 8'h10, 8'h20, 1'b0, 1'b0, 9'h030);

    // Throughput with start held high: done every W+2 cycles.
    @(negedge clk);
    in1 = 8'h81; in2 = 8'h80; c_in = 1'b0; start = 1'b1;
    d0 = -1; d1 = -1; nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (nd == 0) d0 = i;
        else if (nd == 1) d1 = i;
        nd++;
      end
    end
    start = 1'b0;
    chk("thru_period", d1 - d0, W + 2);
    chk("thru_res", {c_out, sum}, 9'h101);
    repeat (12) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub1", 8'h10, 8'h20, 1'b0, 1'b1, 9'h0F0);
    run_op("sub2", 8'h20, 8'h10, 1'b0, 1'b1, 9'h110);
    run_op("sub3", 8'h20, 8'h10, 1'b1, 1'b1, 9'h10F);
    run_op("sub_add", 8'h20, 8'h10, 1'b0, 1'b0, 9'h030);
`endif

    // WIDTH=1 full-adder table; done one cycle after the start edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = i[2]; b1 = i[1]; ci1 = i[0]; st1 = 1'b1;
      @(negedge clk);
      st1 = 1'b0;
      chk("w1_busy", busy1, 1'b1);
      chk("w1_early_done", done1, 1'b0);
      @(negedge clk);
      chk("w1_done", done1, 1'b1);
      chk("w1_res", {co1, sum1}, fa_tbl[i]);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
